// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Copies a program image from word-addressed storage into
//            instruction memory, one 32-bit word per REQ/WRITE pair.
// Revision : 1.0 - initial release
// ============================================================================
module inst_mem_loader (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] SrcAddr,
  input  logic [9:0]  DstAddr,
  input  logic [15:0] WordCount,
  output logic        StoReq,
  output logic [15:0] StoAddr,
  input  logic [31:0] StoData,
  input  logic        StoAck,
  output logic        IMemWe,
  output logic [9:0]  IMemAddr,
  output logic [31:0] IMemData,
  output logic        Busy,
  output logic        InstDst,
  output logic        LoadErr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [7:0] C_TMO_LAST = 8'hFF;

  state_t      state_q;
  logic [15:0] src_q;
  logic [9:0]  dst_q;
  logic [15:0] cnt_q;
  logic [31:0] data_q;
  logic [7:0]  tmo_q;
  logic        sto_req_q;
  logic        imem_we_q;
  logic        busy_q;
  logic        inst_dst_q;
  logic        load_err_q;

  // Output flags are registered alongside the state so they always match it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      sto_req_q  <= 1'b0;
      imem_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      inst_dst_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            src_q <= SrcAddr;
            dst_q <= DstAddr;
            cnt_q <= WordCount;
            if (WordCount == 16'd0) begin
              state_q    <= S_DONE;
              inst_dst_q <= 1'b1;
            end else begin
              state_q   <= S_REQ;
              sto_req_q <= 1'b1;
              busy_q    <= 1'b1;
              tmo_q     <= '0;
            end
          end
        end

        S_REQ: begin
          tmo_q <= tmo_q + 8'd1;
          // An acknowledge in the final timeout cycle still completes the read.
          if (StoAck) begin
            data_q    <= StoData;
            state_q   <= S_WRITE;
            sto_req_q <= 1'b0;
            imem_we_q <= 1'b1;
          end else if (tmo_q == C_TMO_LAST) begin
            state_q    <= S_ERR;
            sto_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            load_err_q <= 1'b1;
          end
        end

        S_WRITE: begin
          imem_we_q <= 1'b0;
          src_q     <= src_q + 16'd1;
          dst_q     <= dst_q + 10'd1;
          cnt_q     <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            inst_dst_q <= 1'b1;
          end else begin
            state_q   <= S_REQ;
            sto_req_q <= 1'b1;
            tmo_q     <= '0;
          end
        end

        S_DONE: begin
          inst_dst_q <= 1'b0;
          state_q    <= S_IDLE;
        end

        S_ERR: begin
          state_q <= S_ERR;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign StoReq   = sto_req_q;
  assign StoAddr  = src_q;
  assign IMemWe   = imem_we_q;
  assign IMemAddr = dst_q;
  assign IMemData = data_q;
  assign Busy     = busy_q;
  assign InstDst  = inst_dst_q;
  assign LoadErr  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// Scoreboard bench for inst_mem_loader: a storage responder feeds data derived
// from the read address; expected writes come from address arithmetic alone.
module tb_inst_mem_loader;

  logic        CLK = 1'b0;
  logic        Reset, Start;
  logic [15:0] SrcAddr;
  logic [9:0]  DstAddr;
  logic [15:0] WordCount;
  logic        StoReq;
  logic [15:0] StoAddr;
  logic [31:0] StoData;
  logic        StoAck;
  logic        IMemWe;
  logic [9:0]  IMemAddr;
  logic [31:0] IMemData;
  logic        Busy, InstDst, LoadErr;

  int checks = 0;
  int errors = 0;

  logic [41:0] exp_wr[$];
  int          exp_done_q[$];

  int ack_delay  = 0;
  bit ack_en     = 1'b1;
  bit rand_delay = 1'b1;
  bit stray_en   = 1'b0;

  always #5 CLK = ~CLK;

  inst_mem_loader dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .WordCount(WordCount), .StoReq(StoReq), .StoAddr(StoAddr), .StoData(StoData),
    .StoAck(StoAck), .IMemWe(IMemWe), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .Busy(Busy), .InstDst(InstDst), .LoadErr(LoadErr)
  );

  function automatic logic [31:0] sto_word(input logic [15:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [62:0] all_outs();
    return {StoReq, StoAddr, IMemWe, IMemAddr, IMemData, Busy, InstDst, LoadErr};
  endfunction

  // Storage model: acks after a programmable number of REQ cycles, returns
  // address-derived data, and optionally injects stray acks outside REQ.
  initial begin : responder
    int wc;
    wc      = 0;
    StoAck  = 1'b0;
    StoData = '0;
    forever begin
      @(negedge CLK);
      StoAck = 1'b0;
      if (StoReq === 1'b1 && ack_en) begin
        if (wc >= ack_delay) begin
          StoAck  = 1'b1;
          StoData = sto_word(StoAddr);
          wc      = 0;
          if (rand_delay) ack_delay = $urandom_range(0, 3);
        end else begin
          wc++;
        end
      end else begin
        wc = 0;
        if (StoReq !== 1'b1 && stray_en && $urandom_range(0, 3) == 0) begin
          StoAck  = 1'b1;
          StoData = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes or signals completion.
  initial begin : monitor
    logic [41:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (IMemWe === 1'b1) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {IMemAddr, IMemData}, 64'h0);
        end else begin
          e = exp_wr.pop_front();
          chk("imem_addr", IMemAddr, e[41:32]);
          chk("imem_data", IMemData, e[31:0]);
        end
      end
      if (InstDst === 1'b1) begin
        chk("inst_dst_expected", exp_done_q.size() != 0, 1);
        chk("writes_before_done", exp_wr.size(), 0);
        if (exp_done_q.size() != 0) void'(exp_done_q.pop_front());
      end
    end
  end

  task automatic start_load(input logic [15:0] s, input logic [9:0] d,
                            input logic [15:0] n, input bit push);
    @(negedge CLK);
    SrcAddr = s; DstAddr = d; WordCount = n; Start = 1'b1;
    if (push) begin
      for (int i = 0; i < int'(n); i++)
        exp_wr.push_back({10'(d + i), sto_word(16'(s + i))});
      exp_done_q.push_back(1);
    end
    @(posedge CLK);
    #1;
    if (n == 16'd0) chk("latency_zero", {StoReq, InstDst, Busy}, 3'b010);
    else            chk("latency_req",  {StoReq, InstDst, Busy}, 3'b101);
    @(negedge CLK);
    Start = 1'b0;
    SrcAddr = 16'($urandom); DstAddr = 10'($urandom); WordCount = 16'($urandom);
  endtask

  // Runs until idle; with noise, fires spurious Start pulses while busy/done.
  task automatic run_to_idle(input int budget, input bit noise);
    int k;
    k = 0;
    while ((Busy || InstDst) && k < budget) begin
      @(negedge CLK);
      Start = noise && (Busy || InstDst) && ($urandom_range(0, 2) == 0);
      if (Start) begin
        SrcAddr = 16'($urandom); DstAddr = 10'($urandom); WordCount = 16'($urandom_range(0, 8));
      end
      k++;
    end
    Start = 1'b0;
    chk("load_finished_in_budget", {Busy, InstDst}, 2'b00);
  endtask

  task automatic do_reset_check(input string name);
    @(negedge CLK);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    chk(name, all_outs(), 63'h0);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin : stim
    int k, reqs;
    logic [15:0] s;
    Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; WordCount = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", all_outs(), 63'h0);
    @(negedge CLK);
    Reset = 1'b0;

    // Basic three-word load, ack one cycle after each request.
    rand_delay = 1'b0; ack_delay = 1;
    start_load(16'h0100, 10'h000, 16'd3, 1'b1);
    run_to_idle(100, 1'b0);
    chk("busy_low_after", Busy, 1'b0);

    // Zero-length load: only a completion pulse.
    start_load(16'h0200, 10'h055, 16'd0, 1'b1);
    run_to_idle(10, 1'b0);

    // Destination and source wrap.
    rand_delay = 1'b1;
    start_load(16'hFFFE, 10'd1022, 16'd3, 1'b1);
    run_to_idle(100, 1'b0);

    // Storage never acknowledges.
    ack_en = 1'b0;
    start_load(16'h3000, 10'h005, 16'd2, 1'b0);
    k = 0; reqs = 0;
    while (!LoadErr && k < 400) begin
      if (StoReq) reqs++;
      @(negedge CLK);
      k++;
    end
    chk("timeout_req_cycles", reqs, 256);
    chk("err_outputs", {LoadErr, StoReq, Busy, IMemWe, InstDst}, 5'b10000);
    Start = 1'b1; WordCount = 16'd1;
    repeat (3) @(negedge CLK);
    Start = 1'b0;
    chk("err_holds_ignores_start", {LoadErr, StoReq, Busy, IMemWe, InstDst}, 5'b10000);
    do_reset_check("reset_from_err");
    ack_en = 1'b1;

    // Ack lands on the last permitted REQ cycle.
    rand_delay = 1'b0; ack_delay = 255;
    start_load(16'h4000, 10'h020, 16'd2, 1'b1);
    run_to_idle(1200, 1'b0);
    chk("late_ack_no_err", LoadErr, 1'b0);

    // Reset during second word's request of a four-word load.
    ack_delay = 0;
    exp_wr.push_back({10'h010, sto_word(16'h2000)});
    start_load(16'h2000, 10'h010, 16'd4, 1'b0);
    k = 0;
    while (!IMemWe && k < 20) begin @(negedge CLK); k++; end
    ack_en = 1'b0;
    @(negedge CLK);
    chk("second_req_addr", {StoReq, StoAddr}, {1'b1, 16'h2001});
    do_reset_check("reset_mid_load");
    ack_en = 1'b1; rand_delay = 1'b1;
    start_load(16'h2100, 10'h3FD, 16'd4, 1'b1);
    run_to_idle(100, 1'b0);

    // Random loads with stray acks and spurious Start pulses.
    stray_en = 1'b1;
    for (int t = 0; t < 25; t++) begin
      s = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom);
      start_load(s, 10'($urandom), 16'($urandom_range(0, 6)), 1'b1);
      run_to_idle(200, 1'b1);
      chk("no_load_err", LoadErr, 1'b0);
    end
    stray_en = 1'b0;

    repeat (3) @(negedge CLK);
    chk("final_wr_queue", exp_wr.size(), 0);
    chk("final_done_queue", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
